// File: rtl/breath_envelope_gen_pkg.sv
// Shared types and helpers for the breathing envelope generator.
// Holds the state encoding, datapath widths and the state-to-phase mapping.
package breath_envelope_gen_pkg;

  localparam int DUTY_W = 8;
  localparam int ENV_W  = 7;
  localparam int HOLD_W = 16;

  typedef enum logic [2:0] {
    ST_MANUAL  = 3'd0,
    ST_RISE    = 3'd1,
    ST_HOLD_HI = 3'd2,
    ST_FALL    = 3'd3,
    ST_HOLD_LO = 3'd4
  } state_t;

  // MANUAL and HOLD_LO share phase 0; both sit at a "low/idle" point.
  function automatic logic [1:0] phase_of(input state_t s);
    logic [1:0] p;
    case (s)
      ST_RISE:    p = 2'd1;
      ST_HOLD_HI: p = 2'd2;
      ST_FALL:    p = 2'd3;
      default:    p = 2'd0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/breath_step_prescaler.sv
// Step-tick prescaler: one tick every max(step_div,1) clk cycles.
// A synchronous clear restarts the count and suppresses the tick.
module breath_step_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [DIV_W-1:0] step_div,
  output logic             tick
);

  logic [DIV_W-1:0] presc;
  logic [DIV_W-1:0] div_last;

  always_comb begin
    div_last = '0;
    if (step_div != '0) div_last = step_div - DIV_W'(1);
  end

  assign tick = !clear && (presc == div_last);

  // A shrinking step_div can leave presc above the new terminal value; wrap it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (clear) begin
      presc <= '0;
    end else if (presc >= div_last) begin
      presc <= '0;
    end else begin
      presc <= presc + DIV_W'(1);
    end
  end

endmodule

// File: rtl/breath_envelope_gen.sv
// Breathing brightness envelope (rise/hold/fall/hold) or manual duty pass-through.
// Duty is handed to the PWM stage only on its period_end strobe.
//
// state      | meaning
// -----------+------------------------------------------------
// ST_MANUAL  | env follows clamped manual_duty, prescaler held
// ST_RISE    | env += STEP per tick, saturating at DUTY_MAX
// ST_HOLD_HI | dwell HOLD_TICKS ticks at the peak
// ST_FALL    | env -= STEP per tick, saturating at 0
// ST_HOLD_LO | dwell HOLD_TICKS ticks at the trough
module breath_envelope_gen
  import breath_envelope_gen_pkg::*;
#(
  parameter int DUTY_MAX   = 100,
  parameter int STEP       = 1,
  parameter int HOLD_TICKS = 8,
  parameter int DIV_W      = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode_breathe,
  input  logic [ENV_W-1:0]  manual_duty,
  input  logic [DIV_W-1:0]  step_div,
  input  logic              period_end,
  output logic [DUTY_W-1:0] duty_out,
  output logic              duty_valid,
  output logic [1:0]        phase
);

  localparam logic [ENV_W-1:0]  ENV_MAX   = ENV_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] STEP_D    = DUTY_W'(STEP);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

  state_t            state;
  logic [ENV_W-1:0]  env;
  logic [HOLD_W-1:0] hold_cnt;
  logic              mode_q;
  logic              tick;
  logic              clear;
  logic [ENV_W-1:0]  manual_clamped;
  logic [DUTY_W-1:0] sum_up;
  logic [ENV_W-1:0]  env_up;
  logic [ENV_W-1:0]  env_dn;
  logic              hold_done;

  assign clear = (state == ST_MANUAL) || (mode_breathe != mode_q);

  breath_step_prescaler #(.DIV_W(DIV_W)) u_presc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .step_div (step_div),
    .tick     (tick)
  );

  // Sums are one bit wider than env so the saturation compare never sees a wrap.
  always_comb begin
    manual_clamped = (manual_duty > ENV_MAX) ? ENV_MAX : manual_duty;
    sum_up         = {1'b0, env} + STEP_D;
    env_up         = (sum_up >= {1'b0, ENV_MAX}) ? ENV_MAX : sum_up[ENV_W-1:0];
    env_dn         = ({1'b0, env} < STEP_D) ? '0 : (env - STEP_D[ENV_W-1:0]);
    hold_done      = (HOLD_TICKS == 0) || (hold_cnt == HOLD_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_MANUAL;
      env      <= '0;
      hold_cnt <= '0;
      mode_q   <= 1'b0;
    end else begin
      mode_q <= mode_breathe;
      if (state == ST_MANUAL) begin
        if (mode_breathe) state <= ST_RISE;
        else              env   <= manual_clamped;
      end else if (!mode_breathe) begin
        state <= ST_MANUAL;
        env   <= manual_clamped;
      end else if (tick) begin
        case (state)
          ST_RISE: begin
            env <= env_up;
            if (env_up == ENV_MAX) begin
              state    <= ST_HOLD_HI;
              hold_cnt <= '0;
            end
          end
          ST_HOLD_HI: begin
            if (hold_done) state    <= ST_FALL;
            else           hold_cnt <= hold_cnt + HOLD_W'(1);
          end
          ST_FALL: begin
            env <= env_dn;
            if (env_dn == '0) begin
              state    <= ST_HOLD_LO;
              hold_cnt <= '0;
            end
          end
          ST_HOLD_LO: begin
            if (hold_done) state    <= ST_RISE;
            else           hold_cnt <= hold_cnt + HOLD_W'(1);
          end
          default: state <= ST_MANUAL;
        endcase
      end
    end
  end

  // Shadow register: env sampled before any same-cycle tick lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_out   <= '0;
      duty_valid <= 1'b0;
    end else if (period_end) begin
      duty_out   <= {1'b0, env};
      duty_valid <= ({1'b0, env} != duty_out);
    end else begin
      duty_valid <= 1'b0;
    end
  end

  assign phase = phase_of(state);

endmodule

// File: tb/tb_breath_envelope_gen.sv
// Directed bench for breath_envelope_gen: default instance plus a STEP=3 /
// HOLD_TICKS=2 instance sharing the same stimulus.
module tb_breath_envelope_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode_breathe = 1'b0;
  logic        period_end = 1'b0;
  logic [6:0]  manual_duty = '0;
  logic [23:0] step_div = 24'd4;
  logic [7:0]  duty_a, duty_b;
  logic        valid_a, valid_b;
  logic [1:0]  phase_a, phase_b;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  breath_envelope_gen dut_a (
    .clk(clk), .rst_n(rst_n), .mode_breathe(mode_breathe), .manual_duty(manual_duty),
    .step_div(step_div), .period_end(period_end), .duty_out(duty_a),
    .duty_valid(valid_a), .phase(phase_a)
  );

  breath_envelope_gen #(.STEP(3), .HOLD_TICKS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .mode_breathe(mode_breathe), .manual_duty(manual_duty),
    .step_div(step_div), .period_end(period_end), .duty_out(duty_b),
    .duty_valid(valid_b), .phase(phase_b)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_pe();
    period_end = 1'b1;
    cyc(1);
    period_end = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // reset held while period_end toggles
    repeat (4) begin
      period_end = ~period_end;
      cyc(1);
    end
    period_end = 1'b0;
    chk("rst_duty", duty_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_phase", phase_a, 0);
    rst_n = 1'b1;

    // manual pass-through with clamp
    manual_duty = 7'd127;
    cyc(2);
    pulse_pe();
    chk("man_duty", duty_a, 100);
    chk("man_valid", valid_a, 1);
    cyc(1);
    chk("man_valid_drop", valid_a, 0);
    pulse_pe();
    chk("man_repeat_valid", valid_a, 0);
    chk("man_repeat_duty", duty_a, 100);

    // breathing, step_div=4: env=k at P(1+4k)
    manual_duty = 7'd0;
    cyc(2);
    mode_breathe = 1'b1;
    cyc(1);                                  // P1
    chk("rise_phase", phase_a, 1);
    chk("rise_env0", dut_a.env, 0);
    cyc(164);                                // P165
    chk("rise_env41", dut_a.env, 41);
    chk("no_pe_duty", duty_a, 100);
    cyc(3);                                  // P168
    pulse_pe();                              // P169: tick 41->42 with period_end
    chk("handoff_duty", duty_a, 41);
    chk("handoff_valid", valid_a, 1);
    chk("handoff_env", dut_a.env, 42);
    cyc(231);                                // P400
    chk("rise_env99", dut_a.env, 99);
    chk("rise_phase99", phase_a, 1);
    cyc(1);                                  // P401
    chk("peak_env", dut_a.env, 100);
    chk("peak_phase", phase_a, 2);
    cyc(31);                                 // P432
    chk("hold_hi_last", phase_a, 2);
    cyc(1);                                  // P433
    chk("fall_phase", phase_a, 3);
    chk("fall_env100", dut_a.env, 100);
    cyc(4);
    chk("fall_env99", dut_a.env, 99);
    cyc(395);                                // P832
    chk("fall_env1", dut_a.env, 1);
    chk("fall_phase1", phase_a, 3);
    cyc(1);                                  // P833
    chk("trough_env", dut_a.env, 0);
    chk("trough_phase", phase_a, 0);
    cyc(31);                                 // P864
    chk("hold_lo_last", phase_a, 0);
    cyc(1);                                  // P865
    chk("rerise_phase", phase_a, 1);
    chk("duty_held", duty_a, 41);

    // mode switch: go to 70, breathe up, hold, fall to 60
    manual_duty = 7'd70;
    mode_breathe = 1'b0;
    cyc(1);                                  // Q1
    chk("sw_man_phase", phase_a, 0);
    chk("sw_man_env", dut_a.env, 70);
    mode_breathe = 1'b1;
    cyc(1);                                  // Q2
    chk("sw_rise_phase", phase_a, 1);
    chk("sw_rise_env", dut_a.env, 70);
    cyc(120);                                // Q122
    chk("sw_peak_phase", phase_a, 2);
    chk("sw_peak_env", dut_a.env, 100);
    cyc(32);                                 // Q154
    chk("sw_fall_phase", phase_a, 3);
    cyc(160);                                // Q314
    chk("sw_fall_env60", dut_a.env, 60);
    mode_breathe = 1'b0;
    manual_duty = 7'd10;
    cyc(1);                                  // Q315
    chk("sw_off_phase", phase_a, 0);
    chk("sw_off_env", dut_a.env, 10);
    mode_breathe = 1'b1;
    cyc(1);                                  // Q316
    chk("sw_on_phase", phase_a, 1);
    chk("sw_on_env", dut_a.env, 10);
    cyc(4);                                  // Q320
    chk("sw_on_env11", dut_a.env, 11);

    // step_div=0 behaves as 1
    step_div = 24'd0;
    cyc(3);
    chk("div0_env", dut_a.env, 14);
    chk("div0_duty_held", duty_a, 41);

    // asynchronous reset mid-RISE
    rst_n = 1'b0;
    #1;
    chk("arst_env", dut_a.env, 0);
    chk("arst_duty", duty_a, 0);
    chk("arst_phase", phase_a, 0);
    chk("arst_valid", valid_a, 0);
    chk("arst_env_b", dut_b.env, 0);
    mode_breathe = 1'b0;
    manual_duty = 7'd0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    chk("post_rst_phase", phase_a, 0);
    manual_duty = 7'd33;
    cyc(1);
    chk("post_rst_manual", dut_a.env, 33);
    manual_duty = 7'd0;
    cyc(1);

    // STEP=3 saturation on both ends, tick every cycle
    mode_breathe = 1'b1;
    cyc(1);                                  // R1
    chk("s3_phase", phase_b, 1);
    cyc(33);                                 // R34
    chk("s3_env99", dut_b.env, 99);
    cyc(1);                                  // R35
    chk("s3_env_sat", dut_b.env, 100);
    chk("s3_peak_phase", phase_b, 2);
    cyc(2);                                  // R37
    chk("s3_fall_phase", phase_b, 3);
    chk("s3_fall_env", dut_b.env, 100);
    cyc(33);                                 // R70
    chk("s3_env1", dut_b.env, 1);
    cyc(1);                                  // R71
    chk("s3_env0", dut_b.env, 0);
    chk("s3_trough_phase", phase_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
